hp_au_issue_pipe: RTL and testbench

//   Sequential issue/retire wrapper around the combinational hp_au_top arithmetic unit.

---
 rtl/hp_au_pkg.sv | 17 +
 rtl/hp_au_issue_pipe_if.sv | 14 +
 rtl/hp_au_cmd_fifo.sv | 41 ++++
 rtl/hp_au_issue_pipe.sv | 59 +++++
 tb/tb_hp_au_issue_pipe.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/hp_au_pkg.sv
// hp_au_pkg: opcodes and command field widths shared by the AU issue pipe.
package hp_au_pkg;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_ADD = 4'd0;
  localparam logic [SEL_W-1:0] SEL_SUB = 4'd1;
  localparam logic [SEL_W-1:0] SEL_BCD = 4'd2;
  localparam logic [SEL_W-1:0] SEL_CLA = 4'd3;
  localparam logic [SEL_W-1:0] SEL_AND = 4'd4;
  localparam logic [SEL_W-1:0] SEL_OR = 4'd5;
  localparam logic [SEL_W-1:0] SEL_XOR = 4'd6;
  localparam logic [SEL_W-1:0] SEL_SHL = 4'd7;
  localparam logic [SEL_W-1:0] SEL_MUL = 4'd8;
  localparam logic [SEL_W-1:0] SEL_LAST_LEGAL = 4'd8;
  function automatic int cmd_w(input int width);
    return 2 * width + SEL_W;
  endfunction
endpackage

// File: rtl/hp_au_issue_pipe_if.sv
// hp_au_issue_pipe_if: command-in and result-out handshake channels of the issue pipe.
interface hp_au_issue_pipe_if #(parameter int WIDTH = 4);
  import hp_au_pkg::*;
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [SEL_W-1:0] in_sel;
  logic out_valid, out_ready, out_err;
  logic [WIDTH-1:0] out_result;
  logic [SEL_W-1:0] out_sel;
  modport master(output in_valid, in_a, in_b, in_sel, out_ready,
                 input in_ready, out_valid, out_result, out_sel, out_err);
  modport slave(input in_valid, in_a, in_b, in_sel, out_ready,
                output in_ready, out_valid, out_result, out_sel, out_err);
endinterface

// File: rtl/hp_au_cmd_fifo.sv
// hp_au_cmd_fifo: synchronous command FIFO with a registered head (zero when empty).
module hp_au_cmd_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic [W-1:0] head_q, head_d;
  assign wr_d = wr_q + (AW + 1)'(push_i);
  assign rd_d = rd_q + (AW + 1)'(pop_i);
  // Head is precomputed for the next cycle, bypassing a write that lands on the new read slot.
  assign head_d = (wr_d == rd_d) ? '0 :
                  (push_i && wr_q[AW-1:0] == rd_d[AW-1:0]) ? wdata_i : mem_q[rd_d[AW-1:0]];
  assign head_o = head_q;
  assign level_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/hp_au_issue_pipe.sv
// hp_au_issue_pipe: buffers AU commands, drives the AU from the FIFO head and registers results.
module hp_au_issue_pipe
  import hp_au_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  hp_au_issue_pipe_if.slave io,
  output logic [WIDTH-1:0] au_a_o,
  output logic [WIDTH-1:0] au_b_o,
  output logic [SEL_W-1:0] au_sel_o,
  input  logic [WIDTH-1:0] au_result_i,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [7:0] ops_done_o
);
  logic full, empty, push, fire;
  logic out_valid_q, out_err_q;
  logic [WIDTH-1:0] out_result_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [7:0] ops_q;
  assign io.in_ready = !full && !rst;
  assign push = io.in_valid && io.in_ready;
  assign fire = !empty && (!out_valid_q || io.out_ready);
  hp_au_cmd_fifo #(.W(cmd_w(WIDTH)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(fire),
    .wdata_i({io.in_a, io.in_b, io.in_sel}),
    .head_o({au_a_o, au_b_o, au_sel_o}),
    .full_o(full),
    .empty_o(empty),
    .level_o(fifo_level_o)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_result_q <= '0;
      out_sel_q <= '0;
      out_err_q <= 1'b0;
      ops_q <= '0;
    end else begin
      if (fire) begin
        out_valid_q <= 1'b1;
        out_result_q <= au_result_i;
        out_sel_q <= au_sel_o;
        out_err_q <= au_sel_o > SEL_LAST_LEGAL;
      end else if (io.out_ready) out_valid_q <= 1'b0;
      if (out_valid_q && io.out_ready) ops_q <= ops_q + 8'd1;
    end
  end
  assign io.out_valid = out_valid_q;
  assign io.out_result = out_result_q;
  assign io.out_sel = out_sel_q;
  assign io.out_err = out_err_q;
  assign ops_done_o = ops_q;
endmodule

// File: tb/tb_hp_au_issue_pipe.sv
// tb_hp_au_issue_pipe: directed scenarios against hp_au_issue_pipe with a behavioural AU.
module tb_hp_au_issue_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] au_a, au_b, au_sel, au_result;
  logic [2:0] level;
  logic [7:0] ops;
  int checks = 0, errors = 0;
  hp_au_issue_pipe_if #(.WIDTH(4)) io ();
  hp_au_issue_pipe #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .io(io),
    .au_a_o(au_a), .au_b_o(au_b), .au_sel_o(au_sel), .au_result_i(au_result),
    .fifo_level_o(level), .ops_done_o(ops)
  );
  always #5 clk = ~clk;
  always_comb begin
    case (au_sel)
      4'd0, 4'd2, 4'd3: au_result = au_a + au_b;
      4'd1: au_result = au_a - au_b;
      4'd4: au_result = au_a & au_b;
      4'd5: au_result = au_a | au_b;
      4'd6: au_result = au_a ^ au_b;
      4'd7: au_result = au_a << au_b[1:0];
      4'd8: au_result = au_a * au_b;
      default: au_result = 4'd0;
    endcase
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    io.in_valid = v;
    io.in_a = a;
    io.in_b = b;
    io.in_sel = s;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    io.out_ready = 1'b0;
    tick;
    tick;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", io.out_valid); end
    checks++; if ({level, ops} !== 11'd0) begin errors++; $display("FAIL rst_level_ops got %0d/%0d exp 0/0", level, ops); end
    checks++; if ({au_a, au_b, au_sel, io.out_result, io.out_sel, io.out_err} !== 21'd0) begin errors++; $display("FAIL rst_zero got %0h exp 0", {au_a, au_b, au_sel, io.out_result, io.out_sel, io.out_err}); end
    rst = 1'b0;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", io.in_ready); end
  endtask
  task automatic test_single_add;
    io.out_ready = 1'b1;
    cmd(1'b1, 4'd3, 4'd5, 4'd0);
    tick;
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL add_t1_valid got %0b exp 0", io.out_valid); end
    checks++; if ({au_a, au_b, au_sel, level} !== {4'd3, 4'd5, 4'd0, 3'd1}) begin errors++; $display("FAIL add_head got a=%0h b=%0h sel=%0h lvl=%0d exp 3 5 0 1", au_a, au_b, au_sel, level); end
    tick;
    checks++; if ({io.out_valid, io.out_result, io.out_sel, io.out_err} !== {1'b1, 4'd8, 4'd0, 1'b0}) begin errors++; $display("FAIL add_result got v=%0b r=%0h s=%0h e=%0b exp 1 8 0 0", io.out_valid, io.out_result, io.out_sel, io.out_err); end
    checks++; if ({au_a, au_b, au_sel, level} !== 15'd0) begin errors++; $display("FAIL add_empty_au got %0h exp 0", {au_a, au_b, au_sel, level}); end
    tick;
    checks++; if ({io.out_valid, ops} !== {1'b0, 8'd1}) begin errors++; $display("FAIL add_retire got v=%0b ops=%0d exp 0 1", io.out_valid, ops); end
  endtask
  task automatic test_back_to_back;
    io.out_ready = 1'b1;
    cmd(1'b1, 4'd9, 4'd2, 4'd1);
    tick;
    cmd(1'b1, 4'd3, 4'd7, 4'd8);
    tick;
    checks++; if ({io.out_valid, io.out_result} !== {1'b1, 4'd7}) begin errors++; $display("FAIL b2b_sub got v=%0b r=%0h exp 1 7", io.out_valid, io.out_result); end
    cmd(1'b1, 4'hA, 4'd5, 4'd6);
    tick;
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    checks++; if ({io.out_valid, io.out_result, io.out_sel} !== {1'b1, 4'd5, 4'd8}) begin errors++; $display("FAIL b2b_mul got v=%0b r=%0h s=%0h exp 1 5 8", io.out_valid, io.out_result, io.out_sel); end
    tick;
    checks++; if ({io.out_valid, io.out_result} !== {1'b1, 4'hF}) begin errors++; $display("FAIL b2b_xor got v=%0b r=%0h exp 1 f", io.out_valid, io.out_result); end
    tick;
    checks++; if ({io.out_valid, ops} !== {1'b0, 8'd4}) begin errors++; $display("FAIL b2b_done got v=%0b ops=%0d exp 0 4", io.out_valid, ops); end
  endtask
  task automatic test_backpressure;
    io.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd(1'b1, 4'(i), 4'd1, 4'd0);
      checks++; if (io.in_ready !== (i < 5)) begin errors++; $display("FAIL bp_in_ready_%0d got %0b exp %0b", i, io.in_ready, i < 5); end
      tick;
    end
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d exp 4", level); end
    checks++; if ({io.out_valid, io.out_result, io.out_sel, io.out_err} !== {1'b1, 4'd1, 4'd0, 1'b0}) begin errors++; $display("FAIL bp_stall_hold got v=%0b r=%0h exp 1 1", io.out_valid, io.out_result); end
    io.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({io.out_valid, io.out_result} !== {1'b1, 4'(k + 1)}) begin errors++; $display("FAIL bp_drain_%0d got v=%0b r=%0h exp 1 %0h", k, io.out_valid, io.out_result, k + 1); end
      tick;
    end
    checks++; if ({io.out_valid, io.in_ready, level, ops} !== {1'b0, 1'b1, 3'd0, 8'd9}) begin errors++; $display("FAIL bp_end got v=%0b rdy=%0b lvl=%0d ops=%0d exp 0 1 0 9", io.out_valid, io.in_ready, level, ops); end
  endtask
  task automatic test_illegal;
    io.out_ready = 1'b1;
    cmd(1'b1, 4'hF, 4'hF, 4'hC);
    tick;
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    tick;
    checks++; if ({io.out_valid, io.out_result, io.out_sel, io.out_err} !== {1'b1, 4'd0, 4'hC, 1'b1}) begin errors++; $display("FAIL illegal got v=%0b r=%0h s=%0h e=%0b exp 1 0 c 1", io.out_valid, io.out_result, io.out_sel, io.out_err); end
    tick;
    checks++; if (ops !== 8'd10) begin errors++; $display("FAIL illegal_ops got %0d exp 10", ops); end
  endtask
  task automatic test_full_pop;
    io.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd(1'b1, 4'(i + 2), 4'd2, 4'd4);
      tick;
    end
    checks++; if ({level, io.out_valid, io.in_ready} !== {3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL full_state got lvl=%0d v=%0b rdy=%0b exp 4 1 0", level, io.out_valid, io.in_ready); end
    cmd(1'b1, 4'd1, 4'd1, 4'd0);
    io.out_ready = 1'b1;
    tick;
    checks++; if ({level, io.in_ready} !== {3'd3, 1'b1}) begin errors++; $display("FAIL full_pop got lvl=%0d rdy=%0b exp 3 1", level, io.in_ready); end
    io.out_ready = 1'b0;
    tick;
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_refill got lvl=%0d exp 4", level); end
    io.out_ready = 1'b1;
    repeat (6) tick;
    checks++; if ({level, io.out_valid, ops} !== {3'd0, 1'b0, 8'd16}) begin errors++; $display("FAIL full_drain got lvl=%0d v=%0b ops=%0d exp 0 0 16", level, io.out_valid, ops); end
  endtask
  task automatic test_reset_mid;
    io.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd(1'b1, 4'(i + 1), 4'd1, 4'd0);
      tick;
    end
    cmd(1'b0, 4'd0, 4'd0, 4'd0);
    checks++; if ({level, io.out_valid} !== {3'd3, 1'b1}) begin errors++; $display("FAIL mid_pre got lvl=%0d v=%0b exp 3 1", level, io.out_valid); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if ({io.out_valid, level, ops, au_a, au_b, au_sel} !== 24'd0) begin errors++; $display("FAIL mid_rst got v=%0b lvl=%0d ops=%0d au=%0h exp all 0", io.out_valid, level, ops, {au_a, au_b, au_sel}); end
    io.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if ({io.out_valid, level} !== 4'd0) begin errors++; $display("FAIL mid_stale_%0d got v=%0b lvl=%0d exp 0 0", k, io.out_valid, level); end
    end
  endtask
  initial begin
    test_reset;
    test_single_add;
    test_back_to_back;
    test_backpressure;
    test_illegal;
    test_full_pop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
